// File: rtl/adder_share_arb.sv
// ============================================================================
// Module      : adder_share_arb
// Description : Round-robin arbiter/sequencer sharing one registered 2-bit
//               adder among NUM_REQ requesters over valid/ready handshakes.
//               Optional sum checker: ADDER_SHARE_ARB_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int ADD_LAT = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [2*NUM_REQ-1:0]   i_req_a,
    input  logic [2*NUM_REQ-1:0]   i_req_b,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic [1:0]             o_add_in0,
    output logic [1:0]             o_add_in1,
    input  logic [2:0]             i_add_out,
    output logic [NUM_REQ-1:0]     o_rsp_valid,
    output logic [2:0]             o_rsp_data,
    input  logic [NUM_REQ-1:0]     i_rsp_ready,
    output logic                   o_busy,
    output logic                   o_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

    localparam logic [1:0]       c_st_idle = 2'd0;
    localparam logic [1:0]       c_st_wait = 2'd1;
    localparam logic [1:0]       c_st_resp = 2'd2;
    localparam logic [CNT_W-1:0] c_lat     = CNT_W'(ADD_LAT);
    localparam logic [PTR_W-1:0] c_last    = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]   c_num     = (PTR_W + 1)'(NUM_REQ);

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       add_in0_q, add_in0_d;
    logic [1:0]       add_in1_q, add_in1_d;
    logic [2:0]       rsp_data_q, rsp_data_d;

    logic             w_win_valid;
    logic [PTR_W-1:0] w_win_idx;
    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_cand;
    logic [1:0]       w_a;
    logic [1:0]       w_b;
    logic             w_accept;
    logic             w_capture;

    // Scan downwards in offset so the candidate closest to rr_ptr wins last.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        w_sum       = '0;
        w_cand      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, rr_ptr_q} + (PTR_W + 1)'(i);
            if (w_sum >= c_num) begin
                w_sum = w_sum - c_num;
            end
            w_cand = w_sum[PTR_W-1:0];
            if (i_req_valid[w_cand]) begin
                w_win_valid = 1'b1;
                w_win_idx   = w_cand;
            end
        end
    end

    always_comb begin
        w_a = 2'b00;
        w_b = 2'b00;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_win_idx == PTR_W'(k)) begin
                w_a = i_req_a[2*k +: 2];
                w_b = i_req_b[2*k +: 2];
            end
        end
    end

    assign w_accept  = (state_q == c_st_idle) && w_win_valid;
    assign w_capture = (state_q == c_st_wait) && (cnt_q == c_lat);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: if (w_accept)               state_d = c_st_wait;
            c_st_wait: if (cnt_q == c_lat)         state_d = c_st_resp;
            c_st_resp: if (i_rsp_ready[owner_q])   state_d = c_st_idle;
            default:                               state_d = c_st_idle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_req_ready = '0;
        o_rsp_valid = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            o_req_ready[k] = w_accept && (w_win_idx == PTR_W'(k));
            o_rsp_valid[k] = (state_q == c_st_resp) && (owner_q == PTR_W'(k));
        end
        o_busy = (state_q != c_st_idle);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        add_in0_d  = add_in0_q;
        add_in1_d  = add_in1_q;
        rsp_data_d = rsp_data_q;
        if (w_accept) begin
            add_in0_d = w_a;
            add_in1_d = w_b;
            owner_d   = w_win_idx;
            rr_ptr_d  = (w_win_idx == c_last) ? '0 : w_win_idx + 1'b1;
            cnt_d     = '0;
        end
        // The counter parks at zero on capture so it never wraps past ADD_LAT.
        if (state_q == c_st_wait) begin
            cnt_d = w_capture ? '0 : cnt_q + 1'b1;
        end
        if (w_capture) begin
            rsp_data_d = i_add_out;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            add_in0_q  <= 2'b00;
            add_in1_q  <= 2'b00;
            rsp_data_q <= 3'b000;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            add_in0_q  <= add_in0_d;
            add_in1_q  <= add_in1_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign o_add_in0  = add_in0_q;
    assign o_add_in1  = add_in1_q;
    assign o_rsp_data = rsp_data_q;

`ifdef ADDER_SHARE_ARB_CHECK_EN
    logic [2:0] exp_q, exp_d;
    logic       err_q, err_d;

    always_comb begin
        exp_d = exp_q;
        if (w_accept) begin
            exp_d = {1'b0, w_a} + {1'b0, w_b};
        end
        err_d = err_q | (w_capture && (i_add_out != exp_q));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            exp_q <= 3'b000;
            err_q <= 1'b0;
        end else begin
            exp_q <= exp_d;
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

`default_nettype wire
